// File: rtl/adc_iq_demod.sv
// I/Q integrate-and-dump demodulator for 3-bit signed converter samples mixed against an 8-point NCO.
// Optional build macro: DEMOD_SCALE_EN (outputs a rounded average instead of the raw sum).
module adc_iq_demod #(
    parameter int LOG2_LEN = 3,
    parameter int ACC_W    = 7 + LOG2_LEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [7:0]              phase_step,
    input  logic [2:0]              adc_db,
    input  logic                    adc_valid,
    output logic [ACC_W-1:0]        i_out,
    output logic [ACC_W-1:0]        q_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_INTEG = 2'd2
    } state_t;

    localparam logic [LOG2_LEN-1:0] CNT_LAST = {LOG2_LEN{1'b1}};

    function automatic logic signed [3:0] cos_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    cos_lut = 4'sd7;
            3'd1:    cos_lut = 4'sd5;
            3'd2:    cos_lut = 4'sd0;
            3'd3:    cos_lut = -4'sd5;
            3'd4:    cos_lut = -4'sd7;
            3'd5:    cos_lut = -4'sd5;
            3'd6:    cos_lut = 4'sd0;
            3'd7:    cos_lut = 4'sd5;
            default: cos_lut = 4'sd0;
        endcase
    endfunction

    function automatic logic signed [3:0] sin_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    sin_lut = 4'sd0;
            3'd1:    sin_lut = 4'sd5;
            3'd2:    sin_lut = 4'sd7;
            3'd3:    sin_lut = 4'sd5;
            3'd4:    sin_lut = 4'sd0;
            3'd5:    sin_lut = -4'sd5;
            3'd6:    sin_lut = -4'sd7;
            3'd7:    sin_lut = -4'sd5;
            default: sin_lut = 4'sd0;
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] scale_sum(input logic signed [ACC_W-1:0] sum);
`ifdef DEMOD_SCALE_EN
        logic signed [ACC_W-1:0] rnd;
        rnd       = ACC_W'(1) <<< (LOG2_LEN - 1);
        scale_sum = (sum + rnd) >>> LOG2_LEN;
`else
        scale_sum = sum;
`endif
    endfunction

    state_t                   state_q, state_d;
    logic [7:0]               phase_q, phase_d;
    logic [7:0]               step_q, step_d;
    logic [LOG2_LEN-1:0]      count_q, count_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_last_q, s1_last_d;
    logic signed [2:0]        s1_db_q, s1_db_d;
    logic signed [3:0]        s1_cos_q, s1_cos_d;
    logic signed [3:0]        s1_sin_q, s1_sin_d;
    logic signed [ACC_W-1:0]  acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0]  acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0]  i_out_q, i_out_d;
    logic signed [ACC_W-1:0]  q_out_q, q_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overrun_q, overrun_d;

    logic                     accept_s;
    logic [7:0]               cur_phase_s;
    logic [7:0]               cur_step_s;
    logic [LOG2_LEN-1:0]      cur_count_s;
    logic signed [6:0]        prod_i_s, prod_q_s;
    logic signed [ACC_W-1:0]  sum_i_s, sum_q_s;

    // The WAIT_VALID state accepts its first sample against a freshly zeroed phase and the live step input.
    assign accept_s    = enable && adc_valid && ((state_q == ST_WAIT) || (state_q == ST_INTEG));
    assign cur_phase_s = (state_q == ST_WAIT) ? 8'd0 : phase_q;
    assign cur_step_s  = (state_q == ST_WAIT) ? phase_step : step_q;
    assign cur_count_s = (state_q == ST_WAIT) ? {LOG2_LEN{1'b0}} : count_q;

    assign prod_i_s = 7'(s1_db_q) * 7'(s1_cos_q);
    assign prod_q_s = 7'(s1_db_q) * 7'(s1_sin_q);
    assign sum_i_s  = acc_i_q + ACC_W'(prod_i_s);
    assign sum_q_s  = acc_q_q + ACC_W'(prod_q_s);

    // Next-state logic for the FSM, NCO, both pipeline stages and the output handshake.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_d      = step_q;
        count_d     = count_q;
        s1_valid_d  = 1'b0;
        s1_last_d   = 1'b0;
        s1_db_d     = s1_db_q;
        s1_cos_d    = s1_cos_q;
        s1_sin_d    = s1_sin_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (!enable) begin
            state_d     = ST_IDLE;
            phase_d     = 8'd0;
            count_d     = {LOG2_LEN{1'b0}};
            acc_i_d     = {ACC_W{1'b0}};
            acc_q_d     = {ACC_W{1'b0}};
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    phase_d = 8'd0;
                    count_d = {LOG2_LEN{1'b0}};
                    step_d  = phase_step;
                    acc_i_d = {ACC_W{1'b0}};
                    acc_q_d = {ACC_W{1'b0}};
                    if (adc_valid) begin
                        state_d = ST_INTEG;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_INTEG: begin
                    state_d = ST_INTEG;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (accept_s) begin
                phase_d    = cur_phase_s + cur_step_s;
                count_d    = cur_count_s + LOG2_LEN'(1);
                s1_valid_d = 1'b1;
                s1_last_d  = (cur_count_s == CNT_LAST);
                s1_db_d    = adc_db;
                s1_cos_d   = cos_lut(cur_phase_s[7:5]);
                s1_sin_d   = sin_lut(cur_phase_s[7:5]);
            end else begin
                s1_valid_d = 1'b0;
            end

            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end

            // A dump restarts the accumulator at zero; the next sample is already in stage 1, so none is lost.
            if (s1_valid_q && s1_last_q) begin
                i_out_d     = scale_sum(sum_i_s);
                q_out_d     = scale_sum(sum_q_s);
                acc_i_d     = {ACC_W{1'b0}};
                acc_q_d     = {ACC_W{1'b0}};
                out_valid_d = 1'b1;
                if (out_valid_q && !out_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end else if (s1_valid_q) begin
                acc_i_d = sum_i_s;
                acc_q_d = sum_q_s;
            end else begin
                overrun_d = overrun_q;
            end
        end
    end

    // State, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= 8'd0;
            step_q      <= 8'd0;
            count_q     <= {LOG2_LEN{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_db_q     <= 3'sd0;
            s1_cos_q    <= 4'sd0;
            s1_sin_q    <= 4'sd0;
            acc_i_q     <= {ACC_W{1'b0}};
            acc_q_q     <= {ACC_W{1'b0}};
            i_out_q     <= {ACC_W{1'b0}};
            q_out_q     <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            step_q      <= step_d;
            count_q     <= count_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_db_q     <= s1_db_d;
            s1_cos_q    <= s1_cos_d;
            s1_sin_q    <= s1_sin_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_iq_demod.sv
// Directed self-checking bench for adc_iq_demod (LOG2_LEN=3); expectations follow DEMOD_SCALE_EN if defined.
module tb_adc_iq_demod;

    localparam int LOG2_LEN = 3;
    localparam int ACC_W    = 7 + LOG2_LEN;
`ifdef DEMOD_SCALE_EN
    localparam int EXP_SINE_I = 10;
`else
    localparam int EXP_SINE_I = 82;
`endif

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic [7:0]              phase_step;
    logic [2:0]              adc_db;
    logic                    adc_valid;
    logic signed [ACC_W-1:0] i_out;
    logic signed [ACC_W-1:0] q_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [2:0] pat_a [8] = '{3'sd3, 3'sd2, 3'sd0, -3'sd2, -3'sd3, -3'sd2, 3'sd0, 3'sd2};

    adc_iq_demod #(.LOG2_LEN(LOG2_LEN), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .phase_step (phase_step),
        .adc_db     (adc_db),
        .adc_valid  (adc_valid),
        .i_out      (i_out),
        .q_out      (q_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in WAIT_VALID with nothing in flight.
    task automatic start_run();
        adc_valid = 1'b0;
        enable    = 1'b0;
        step();
        enable    = 1'b1;
        step();
    endtask

    // sel 0: sine-like pattern, sel 1: constant 3. gap=1 presents a sample every other cycle.
    task automatic run_pattern(input int sel, input int gap, input int ncycles,
                               input int exp_i, input int exp_q, input string tag);
        int n;
        int due;
        logic present;
        n   = 0;
        due = -1;
        for (int t = 0; t < ncycles; t++) begin
            present = (gap == 0) || ((t % 2) == 0);
            if (present) begin
                adc_valid = 1'b1;
                adc_db    = (sel == 0) ? pat_a[n % 8] : 3'sd3;
                if ((n % 8) == 7) due = t + 1;
                n++;
            end else begin
                adc_valid = 1'b0;
            end
            step();
            check_val({tag, "_valid"}, out_valid, (t == due) ? 1 : 0);
            if (t == due) begin
                check_val({tag, "_i"}, i_out, exp_i);
                check_val({tag, "_q"}, q_out, exp_q);
            end
        end
        adc_valid = 1'b0;
    endtask

    initial begin
        int seen_valid;
        rst_n      = 1'b0;
        enable     = 1'b0;
        phase_step = 8'd32;
        adc_db     = 3'd0;
        adc_valid  = 1'b0;
        out_ready  = 1'b1;
        #12;
        check_val("rst_i", i_out, 0);
        check_val("rst_q", q_out, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_overrun", overrun, 0);

        rst_n = 1'b1;
        step();
        seen_valid = 0;
        for (int k = 0; k < 20; k++) begin
            adc_valid = k[0];
            adc_db    = 3'd3;
            step();
            if (out_valid) seen_valid++;
        end
        check_val("idle_valid_seen", seen_valid, 0);
        check_val("idle_i", i_out, 0);
        adc_valid = 1'b0;

        start_run();
        run_pattern(0, 0, 25, EXP_SINE_I, 0, "cont");

        start_run();
        run_pattern(1, 0, 17, 0, 0, "const");

        start_run();
        run_pattern(0, 1, 48, EXP_SINE_I, 0, "gap");

        // Overrun: no acceptance across two dumps.
        start_run();
        out_ready = 1'b0;
        for (int n = 0; n < 17; n++) begin
            adc_valid = 1'b1;
            adc_db    = pat_a[n % 8];
            step();
            if (n == 8) begin
                check_val("ovr_first_valid", out_valid, 1);
                check_val("ovr_first_flag", overrun, 0);
            end
            if (n == 16) begin
                check_val("ovr_second_valid", out_valid, 1);
                check_val("ovr_second_flag", overrun, 1);
                check_val("ovr_second_i", i_out, EXP_SINE_I);
            end
        end
        adc_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check_val("ovr_accept_valid", out_valid, 0);
        check_val("ovr_sticky", overrun, 1);
        enable = 1'b0;
        step();
        check_val("ovr_cleared", overrun, 0);

        // Partial integration then restart: stale samples and phase must be discarded.
        start_run();
        for (int n = 0; n < 5; n++) begin
            adc_valid = 1'b1;
            adc_db    = -3'sd4;
            step();
        end
        start_run();
        run_pattern(0, 0, 9, EXP_SINE_I, 0, "restart");

        // Asynchronous reset while a result is held.
        start_run();
        out_ready = 1'b0;
        for (int n = 0; n < 12; n++) begin
            adc_valid = 1'b1;
            adc_db    = pat_a[n % 8];
            step();
        end
        check_val("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_i", i_out, 0);
        check_val("async_rst_valid", out_valid, 0);
        check_val("async_rst_overrun", overrun, 0);
        adc_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
